// File: rtl/can_ctrl_pkg.sv
// Shared definitions for the CAN RX frame writer: RAM slot word offsets,
// header bit positions, the write-sequencer state enum, the latched frame
// record, and helpers that mask the payload and assemble each slot word.
package can_ctrl_pkg;

  // Word offsets inside a 4-word slot
  localparam logic [1:0] OFF_HDR0 = 2'd0;  // {ide, rtr, 0, id}
  localparam logic [1:0] OFF_HDR1 = 2'd1;  // {ts, 12'h000, dlc}
  localparam logic [1:0] OFF_D0   = 2'd2;  // data bytes 3..0
  localparam logic [1:0] OFF_D1   = 2'd3;  // data bytes 7..4

  // Header bit positions
  localparam int IDE_BIT = 31;
  localparam int RTR_BIT = 30;
  localparam int TS_LSB  = 16;

  // Write sequencer. Data words go first and the header word last, so a
  // slot only becomes meaningful to the CPU once wr_ptr moves past it.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W_D0 = 3'd1,
    W_D1 = 3'd2,
    W_H1 = 3'd3,
    W_H0 = 3'd4
  } wr_state_e;

  // Frame as captured at acceptance (payload already masked)
  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [15:0] ts;
  } frame_t;

  // Zero every byte at or beyond the DLC, and all bytes of a remote frame.
  // A DLC above 8 keeps all eight bytes.
  function automatic logic [63:0] mask_payload(input logic [63:0] data,
                                               input logic [3:0]  dlc,
                                               input logic        rtr);
    logic [63:0] m;
    m = data;
    for (int i = 0; i < 8; i++) begin
      if (rtr || (dlc <= 4'(i))) begin
        m[i*8 +: 8] = 8'h00;
      end
    end
    return m;
  endfunction

  // Slot word for a given offset
  function automatic logic [31:0] pack_word(input logic [1:0] off,
                                            input frame_t     f);
    logic [31:0] w;
    w = '0;
    case (off)
      OFF_HDR0: begin
        w[28:0]    = f.id;
        w[IDE_BIT] = f.ide;
        w[RTR_BIT] = f.rtr;
      end
      OFF_HDR1: begin
        w[3:0]          = f.dlc;
        w[TS_LSB +: 16] = f.ts;
      end
      OFF_D0:  w = f.data[31:0];
      default: w = f.data[63:32];
    endcase
    return w;
  endfunction

  // Which slot word a write state puts on the bus
  function automatic logic [1:0] state_offset(input wr_state_e s);
    logic [1:0] off;
    case (s)
      W_D0:    off = OFF_D0;
      W_D1:    off = OFF_D1;
      W_H1:    off = OFF_HDR1;
      default: off = OFF_HDR0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/can_rx_ts_counter.sv
// Timestamp source for received frames: a TS_DIV prescaler feeding a
// free-running 16-bit tick counter that wraps from FFFF to 0.
// Ports: clk, reset (async, active-high), ts[15:0] current tick count.
module can_rx_ts_counter #(
  parameter int TS_DIV = 50
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] ts
);

  localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TS_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   ts_q, ts_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
    ts_d  = tick ? ts_q + 16'd1 : ts_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      ts_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ts_q  <= ts_d;
    end
  end

  assign ts = ts_q;

endmodule

// File: rtl/can_rx_frame_writer.sv
// Writes received CAN frames into a ring of 4-word slots in on-chip RAM.
// One frame is accepted in IDLE, then four back-to-back RAM writes follow
// (data words first, header last) and wr_ptr commits on the final write.
// Ports: clk/reset; frm_* valid/ready frame input with capture enable en;
// sw_rd_ptr/ovf_clr from the CPU; wr_ptr/fill/ovf_cnt/irq status; and the
// RAM write-only slave port (address, byteenable, chipselect, write,
// writedata, clken). The RAM has no waitrequest, so writes never stall.
module can_rx_frame_writer
  import can_ctrl_pkg::*;
#(
  parameter logic [9:0] BASE_WORD  = 10'h200,
  parameter int         SLOT_W     = 6,
  parameter int         TS_DIV     = 50,
  parameter int         IRQ_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              frm_valid,
  output logic              frm_ready,
  input  logic [28:0]       frm_id,
  input  logic              frm_ide,
  input  logic              frm_rtr,
  input  logic [3:0]        frm_dlc,
  input  logic [63:0]       frm_data,
  input  logic [SLOT_W:0]   sw_rd_ptr,
  input  logic              ovf_clr,
  output logic [SLOT_W:0]   wr_ptr,
  output logic [SLOT_W:0]   fill,
  output logic [7:0]        ovf_cnt,
  output logic              irq,
  output logic [9:0]        address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken
);

  localparam logic [SLOT_W:0] FULL_LVL = {1'b1, {SLOT_W{1'b0}}};
  localparam logic [SLOT_W:0] IRQ_LVL  = (SLOT_W+1)'(IRQ_THRESH);

  logic [15:0] ts;

  can_rx_ts_counter #(
    .TS_DIV(TS_DIV)
  ) u_ts (
    .clk   (clk),
    .reset (reset),
    .ts    (ts)
  );

  wr_state_e       state_q, state_d;
  frame_t          frame_q, frame_d;
  frame_t          frame_in;
  logic [SLOT_W:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]      ovf_cnt_q, ovf_cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [9:0]      address_q, address_d;
  logic [31:0]     writedata_q, writedata_d;

  logic            hs;
  logic            ring_full;
  logic            drop;
  logic [SLOT_W:0] fill_w;
  logic [1:0]      next_off;
  logic [SLOT_W+1:0] slot_rel;

  // Frame as it will be stored; timestamp sampled in the handshake cycle
  assign frame_in = '{id:   frm_id,
                      ide:  frm_ide,
                      rtr:  frm_rtr,
                      dlc:  frm_dlc,
                      data: mask_payload(frm_data, frm_dlc, frm_rtr),
                      ts:   ts};

  // Reset gates ready so the RX engine cannot hand over a frame while the
  // sequencer is held; it rises as soon as reset drops.
  assign frm_ready = (state_q == IDLE) & ~reset;
  assign hs        = frm_valid & frm_ready;

  // Modulo arithmetic on the wrap-bit pointers gives the occupancy directly
  assign fill_w    = wr_ptr_q - sw_rd_ptr;
  assign ring_full = (fill_w == FULL_LVL);

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    wr_ptr_d    = wr_ptr_q;
    ovf_cnt_d   = ovf_cnt_q;
    wr_en_d     = 1'b0;
    address_d   = '0;
    writedata_d = '0;
    drop        = 1'b0;
    next_off    = OFF_HDR0;
    slot_rel    = '0;

    case (state_q)
      IDLE: begin
        if (hs) begin
          frame_d = frame_in;
          if (en) begin
            if (ring_full) begin
              drop = 1'b1;
            end else begin
              state_d = W_D0;
            end
          end
        end
      end
      W_D0:    state_d = W_D1;
      W_D1:    state_d = W_H1;
      W_H1:    state_d = W_H0;
      W_H0: begin
        // Header word is on the bus this cycle; publish the slot
        state_d  = IDLE;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered: prepare the word for the state being
    // entered. wr_ptr only moves after the last write, so the slot index is
    // stable for the whole sequence.
    if (state_d != IDLE) begin
      next_off    = state_offset(state_d);
      slot_rel    = {wr_ptr_q[SLOT_W-1:0], next_off};
      wr_en_d     = 1'b1;
      address_d   = BASE_WORD + 10'(slot_rel);
      writedata_d = pack_word(next_off, frame_d);
    end

    // A clear coinciding with a drop keeps that drop counted
    if (drop) begin
      if (ovf_clr) begin
        ovf_cnt_d = 8'd1;
      end else if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end else if (ovf_clr) begin
      ovf_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      wr_ptr_q    <= '0;
      ovf_cnt_q   <= '0;
      wr_en_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      wr_ptr_q    <= wr_ptr_d;
      ovf_cnt_q   <= ovf_cnt_d;
      wr_en_q     <= wr_en_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
    end
  end

  assign wr_ptr     = wr_ptr_q;
  assign fill       = fill_w;
  assign ovf_cnt    = ovf_cnt_q;
  assign irq        = en & (fill_w >= IRQ_LVL);
  assign address    = address_q;
  assign byteenable = 4'hF;
  assign chipselect = wr_en_q;
  assign write      = wr_en_q;
  assign writedata  = writedata_q;
  assign clken      = 1'b1;

endmodule

// File: tb/tb_can_rx_frame_writer.sv
// Bench for can_rx_frame_writer (SLOT_W=6, TS_DIV=4, BASE 0x200): table of
// known frames, hand sequences for throughput, ring full / overflow, reset
// mid-frame and timestamp spacing, then randomized frames vs. a slot model.
module tb_can_rx_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        frm_valid = 1'b0;
  logic        frm_ready;
  logic [28:0] frm_id = '0;
  logic        frm_ide = 1'b0;
  logic        frm_rtr = 1'b0;
  logic [3:0]  frm_dlc = '0;
  logic [63:0] frm_data = '0;
  logic [6:0]  sw_rd_ptr = '0;
  logic        ovf_clr = 1'b0;
  logic [6:0]  wr_ptr;
  logic [6:0]  fill;
  logic [7:0]  ovf_cnt;
  logic        irq;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        clken;

  always #5 clk = ~clk;

  can_rx_frame_writer #(
    .BASE_WORD(10'h200), .SLOT_W(6), .TS_DIV(4), .IRQ_THRESH(1)
  ) dut (
    .clk(clk), .reset(rst), .en(en),
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_id(frm_id), .frm_ide(frm_ide), .frm_rtr(frm_rtr),
    .frm_dlc(frm_dlc), .frm_data(frm_data),
    .sw_rd_ptr(sw_rd_ptr), .ovf_clr(ovf_clr),
    .wr_ptr(wr_ptr), .fill(fill), .ovf_cnt(ovf_cnt), .irq(irq),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .clken(clken)
  );

  int errors = 0;
  int checks = 0;

  // Clock edges since reset release; timestamp = cyc / TS_DIV
  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // RAM model plus a log of every write with its cycle
  typedef struct {
    int          c;
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t         wlog[$];
  logic [31:0] mem [0:1023];

  always @(negedge clk) begin
    if (chipselect && write) begin
      wr_t e;
      e.c = cyc;
      e.a = address;
      e.d = writedata;
      wlog.push_back(e);
      mem[address] = writedata;
    end
  end

  // Reference state
  logic [6:0] wr_m = '0;
  logic [7:0] ovf_m = '0;
  bit         tog_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Slot contents straight from the storage rules: {off3, off2, off1, off0}
  function automatic logic [127:0] model_words(input logic [28:0] id, input logic ide,
                                               input logic rtr, input logic [3:0] dlc,
                                               input logic [63:0] data, input logic [15:0] ts);
    int n;
    logic [63:0] p;
    n = (dlc > 4'd8) ? 8 : int'(dlc);
    p = '0;
    if (!rtr) begin
      for (int b = 0; b < n; b++) p[b*8 +: 8] = data[b*8 +: 8];
    end
    return {p[63:32], p[31:0], ts, 12'h000, dlc, ide, rtr, 1'b0, id};
  endfunction

  // Present one frame; returns the handshake cycle, leaves time at T+1
  task automatic send(input logic [28:0] id, input logic ide, input logic rtr,
                      input logic [3:0] dlc, input logic [63:0] data,
                      input logic en_v, input logic clr, output int hs);
    int guard;
    guard = 0;
    @(negedge clk);
    en = en_v;
    frm_id = id; frm_ide = ide; frm_rtr = rtr; frm_dlc = dlc; frm_data = data;
    frm_valid = 1'b1;
    while (!frm_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!frm_ready) chk("ready_timeout", {63'b0, frm_ready}, 64'd1);
    ovf_clr = clr;
    hs = cyc;
    @(negedge clk);
    frm_valid = 1'b0;
    ovf_clr = 1'b0;
    if (tog_en) en = ~en_v;
  endtask

  task automatic run_frame(input logic [28:0] id, input logic ide, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data,
                           input logic en_v, input logic clr, input logic use_tab,
                           input logic [31:0] t0, input logic [31:0] t2,
                           input logic [31:0] t3, output int hs);
    logic full_m, wr_exp;
    logic [127:0] w;
    logic [31:0] ew;
    logic [6:0] fill_m;
    int off;
    int order[4];
    order = '{2, 3, 1, 0};
    full_m = (7'(wr_m - sw_rd_ptr) == 7'd64);
    send(id, ide, rtr, dlc, data, en_v, clr, hs);
    wr_exp = en_v && !full_m;
    if (en_v && full_m) ovf_m = clr ? 8'd1 : ((ovf_m == 8'hFF) ? 8'hFF : ovf_m + 8'd1);
    else if (clr)       ovf_m = 8'd0;
    w = model_words(id, ide, rtr, dlc, data, 16'(hs / 4));
    if (use_tab) begin
      w[31:0] = t0; w[95:64] = t2; w[127:96] = t3;
    end
    repeat (4) @(negedge clk);
    chk("write_count", 64'(wlog.size()), wr_exp ? 64'd4 : 64'd0);
    if (wr_exp) begin
      for (int k = 0; k < 4; k++) begin
        off = order[k];
        ew = w[off*32 +: 32];
        if (k < wlog.size())
          chk("slot_write", {8'(wlog[k].c - hs), 14'(wlog[k].a), wlog[k].d},
              {8'(k + 1), 14'(10'h200 + {wr_m[5:0], 2'(off)}), ew});
      end
      wr_m = wr_m + 7'd1;
    end
    wlog.delete();
    fill_m = 7'(wr_m - sw_rd_ptr);
    chk("wr_ptr", 64'(wr_ptr), 64'(wr_m));
    chk("fill", 64'(fill), 64'(fill_m));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(ovf_m));
    chk("irq", 64'(irq), 64'(en && (fill_m >= 7'd1)));
  endtask

  task automatic rand_frame(input logic en_v, input logic clr, output int hs);
    logic ide, rtr;
    logic [28:0] id;
    ide = 1'($urandom_range(0, 1));
    id  = ide ? 29'($urandom) : 29'($urandom_range(0, 2047));
    rtr = ($urandom_range(0, 3) == 0);
    run_frame(id, ide, rtr, 4'($urandom_range(0, 15)), {$urandom, $urandom},
              en_v, clr, 1'b0, '0, '0, '0, hs);
  endtask

  typedef struct {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [31:0] w0;
    logic [31:0] w2;
    logic [31:0] w3;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tab[7];
    int hs, hs_b, n_hs, n_low;
    logic [9:0] a_ts, b_ts;
    logic [15:0] ts_a, ts_b;

    tab[0] = '{29'h123,      1'b0, 1'b0, 4'd2,  64'h000000000000BBAA, 32'h00000123, 32'h0000BBAA, 32'h00000000};
    tab[1] = '{29'h1ABCDEF0, 1'b1, 1'b1, 4'd8,  64'h1122334455667788, 32'hDABCDEF0, 32'h00000000, 32'h00000000};
    tab[2] = '{29'h7FF,      1'b0, 1'b0, 4'd0,  64'hFFFFFFFFFFFFFFFF, 32'h000007FF, 32'h00000000, 32'h00000000};
    tab[3] = '{29'h2AA,      1'b0, 1'b0, 4'd5,  64'h8877665544332211, 32'h000002AA, 32'h44332211, 32'h00000055};
    tab[4] = '{29'h1FFFFFFF, 1'b1, 1'b0, 4'd15, 64'hF0E0D0C0B0A09080, 32'h9FFFFFFF, 32'hB0A09080, 32'hF0E0D0C0};
    tab[5] = '{29'h0,        1'b0, 1'b0, 4'd8,  64'h0123456789ABCDEF, 32'h00000000, 32'h89ABCDEF, 32'h01234567};
    tab[6] = '{29'h5A5,      1'b0, 1'b1, 4'd4,  64'hDEADBEEFCAFEF00D, 32'h400005A5, 32'h00000000, 32'h00000000};

    // Reset state
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(frm_ready), 64'd0);
    chk("rst_cs", 64'(chipselect), 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_addr", 64'(address), 64'd0);
    chk("rst_wdata", 64'(writedata), 64'd0);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    chk("byteenable", 64'(byteenable), 64'hF);
    chk("clken", 64'(clken), 64'd1);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(frm_ready), 64'd1);

    // Known frames
    for (int i = 0; i < 7; i++)
      run_frame(tab[i].id, tab[i].ide, tab[i].rtr, tab[i].dlc, tab[i].data,
                1'b1, 1'b0, 1'b1, tab[i].w0, tab[i].w2, tab[i].w3, hs);

    // Back-to-back: 10 frames in 50 cycles, ready low 4 cycles each
    @(negedge clk);
    en = 1'b1; frm_id = 29'h100; frm_ide = 1'b0; frm_rtr = 1'b0;
    frm_dlc = 4'd8; frm_data = 64'hA5A5A5A55A5A5A5A; frm_valid = 1'b1;
    n_hs = 0; n_low = 0;
    for (int i = 0; i < 50; i++) begin
      if (frm_ready) n_hs++;
      else           n_low++;
      @(negedge clk);
    end
    frm_valid = 1'b0;
    wr_m = wr_m + 7'd10;
    @(negedge clk);
    chk("b2b_frames", 64'(n_hs), 64'd10);
    chk("b2b_ready_low", 64'(n_low), 64'd40);
    chk("b2b_writes", 64'(wlog.size()), 64'd40);
    chk("b2b_wr_ptr", 64'(wr_ptr), 64'(wr_m));
    wlog.delete();

    // Fill the ring with sw_rd_ptr=0, then overflow handling
    sw_rd_ptr = 7'd0;
    for (int i = 0; i < 100 && wr_m != 7'd64; i++) rand_frame(1'b1, 1'b0, hs);
    rand_frame(1'b1, 1'b0, hs);   // dropped, ovf=1
    rand_frame(1'b0, 1'b0, hs);   // en=0: discarded, not counted
    rand_frame(1'b1, 1'b0, hs);   // ovf=2
    rand_frame(1'b1, 1'b1, hs);   // clear with drop -> 1
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0; ovf_m = 8'd0;
    chk("ovf_clr_alone", 64'(ovf_cnt), 64'd0);
    sw_rd_ptr = 7'd1;
    rand_frame(1'b1, 1'b0, hs);   // lands in slot 0
    chk("wrap_wr_ptr", 64'(wr_ptr), 64'd65);

    // Saturation: hold valid on a full ring
    sw_rd_ptr = 7'(wr_m - 7'd64);
    @(negedge clk);
    en = 1'b1; frm_valid = 1'b1;
    repeat (300) @(negedge clk);
    frm_valid = 1'b0;
    @(negedge clk);
    ovf_m = 8'hFF;
    chk("ovf_saturate", 64'(ovf_cnt), 64'hFF);
    chk("full_no_write", 64'(wlog.size()), 64'd0);
    chk("full_wr_ptr", 64'(wr_ptr), 64'(wr_m));

    // Randomized frames against the model
    tog_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) sw_rd_ptr = 7'(wr_m - 7'($urandom_range(0, 64)));
      rand_frame($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, hs);
    end
    tog_en = 1'b0;

    // Timestamp spacing: handshakes 40 cycles apart at TS_DIV=4
    sw_rd_ptr = wr_m;
    a_ts = 10'h200 + {wr_m[5:0], 2'd1};
    rand_frame(1'b1, 1'b0, hs);
    repeat (34) @(negedge clk);
    b_ts = 10'h200 + {wr_m[5:0], 2'd1};
    rand_frame(1'b1, 1'b0, hs_b);
    ts_a = mem[a_ts][31:16];
    ts_b = mem[b_ts][31:16];
    chk("ts_delta", 64'(16'(ts_b - ts_a)), 64'd10);

    // Reset at T+2 of a frame: no commit, next frame goes to slot 0
    sw_rd_ptr = wr_m;
    send(29'h55, 1'b0, 1'b0, 4'd8, 64'h1122334455667788, 1'b1, 1'b0, hs);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(frm_ready), 64'd0);
    chk("midrst_cs", 64'(chipselect), 64'd0);
    chk("midrst_wr_ptr", 64'(wr_ptr), 64'd0);
    repeat (2) @(negedge clk);
    chk("midrst_ready_hold", 64'(frm_ready), 64'd0);
    rst = 1'b0;
    sw_rd_ptr = 7'd0; wr_m = 7'd0; ovf_m = 8'd0;
    #1;
    chk("midrst_ready_rel", 64'(frm_ready), 64'd1);
    chk("midrst_no_commit", 64'(wr_ptr), 64'd0);
    wlog.delete();
    run_frame(tab[0].id, tab[0].ide, tab[0].rtr, tab[0].dlc, tab[0].data,
              1'b1, 1'b0, 1'b1, tab[0].w0, tab[0].w2, tab[0].w3, hs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
